// File: rtl/mult_div_sequencer.sv
// Iterative signed multiply/divide sequencer for HI/LO: WIDTH-step shift-add
// multiply or restoring divide on operand magnitudes, then a sign-fix cycle.
module mult_div_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             Reset,
  input  logic             MultCtrl,
  input  logic             DivCtrl,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic             DivZero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t             state_q, state_d;
  logic               op_div_q, op_div_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic               sign_q, sign_d;
  logic               rsign_q, rsign_d;
  logic               dz_q, dz_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mult_sum;
  logic [WIDTH:0]     shifted;
  logic [WIDTH+1:0]   diff;
  logic [2*WIDTH-1:0] prod;

  always_comb begin
    state_d  = state_q;
    op_div_d = op_div_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opb_d    = opb_q;
    sign_d   = sign_q;
    rsign_d  = rsign_q;
    dz_d     = dz_q;
    hi_d     = hi_q;
    lo_d     = lo_q;

    a_mag    = a_in[WIDTH-1] ? -a_in : a_in;
    b_mag    = b_in[WIDTH-1] ? -b_in : b_in;
    // Multiply: acc holds {partial product, remaining multiplier bits}.
    mult_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opb_q : '0)};
    // Divide: acc holds {partial remainder, remaining dividend / quotient bits}.
    shifted  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    diff     = {1'b0, shifted} - {2'b00, opb_q};
    prod     = sign_q ? -acc_q : acc_q;

    case (state_q)
      IDLE: begin
        if (MultCtrl) begin
          op_div_d = 1'b0;
          acc_d    = {{WIDTH{1'b0}}, b_mag};
          opb_d    = a_mag;
          sign_d   = a_in[WIDTH-1] ^ b_in[WIDTH-1];
          rsign_d  = 1'b0;
          cnt_d    = '0;
          dz_d     = 1'b0;
          state_d  = RUN;
        end else if (DivCtrl) begin
          cnt_d = '0;
          if (b_in == '0) begin
            dz_d    = 1'b1;
            state_d = DONE;
          end else begin
            op_div_d = 1'b1;
            acc_d    = {{WIDTH{1'b0}}, a_mag};
            opb_d    = b_mag;
            sign_d   = a_in[WIDTH-1] ^ b_in[WIDTH-1];
            rsign_d  = a_in[WIDTH-1];
            dz_d     = 1'b0;
            state_d  = RUN;
          end
        end
      end
      RUN: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (op_div_q) begin
          acc_d = {(diff[WIDTH+1] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0]),
                   acc_q[WIDTH-2:0], ~diff[WIDTH+1]};
        end else begin
          acc_d = {mult_sum, acc_q[WIDTH-1:1]};
        end
        if (cnt_q == LAST) state_d = FIX;
      end
      FIX: begin
        if (op_div_q) begin
          lo_d = sign_q  ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
          hi_d = rsign_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
        end else begin
          {hi_d, lo_d} = prod;
        end
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge Reset) begin
    if (!Reset) begin
      state_q  <= IDLE;
      op_div_q <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      opb_q    <= '0;
      sign_q   <= 1'b0;
      rsign_q  <= 1'b0;
      dz_q     <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      op_div_q <= op_div_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opb_q    <= opb_d;
      sign_q   <= sign_d;
      rsign_q  <= rsign_d;
      dz_q     <= dz_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign busy    = (state_q == RUN) || (state_q == FIX);
  assign done    = (state_q == DONE);
  assign DivZero = dz_q;
  assign hi      = hi_q;
  assign lo      = lo_q;

endmodule

// File: doc/mult_div_sequencer.md
Name: mult_div_sequencer

Overview:
- Sequences the iterative signed multiply/divide resource for mult/div instructions (funct 0x18 / 0x1A); the main multicycle controller starts it via MultCtrl/DivCtrl pulses.
- Captures both operands, runs a WIDTH-step shift-add multiply or restoring divide, applies sign correction, then holds the result in HI/LO.
- Raises busy while running and pulses done on completion, so the controller can stall until HI/LO are valid.

Parameters:
- WIDTH, 32, operand width; HI/LO are WIDTH each.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clock  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- MultCtrl  in  1  start signed multiply, one-cycle pulse.
- DivCtrl  in  1  start signed divide, one-cycle pulse.
- a_in  in  WIDTH  operand A from register A (multiplicand / dividend).
- b_in  in  WIDTH  operand B from register B (multiplier / divisor).
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle completion pulse.
- DivZero  out  1  divide-by-zero flag, valid with done.
- hi  out  WIDTH  HI register: upper product half / remainder.
- lo  out  WIDTH  LO register: lower product half / quotient.

Behaviour:
- Reset low, asynchronously: state=IDLE; busy=0, done=0, DivZero=0, hi=0, lo=0; counter and internal operand registers cleared.
- Reset mid-operation aborts the operation. No done is issued, and HI/LO read 0 after reset.
- States: IDLE, RUN, FIX, DONE.
- IDLE:
  - MultCtrl=1 → latch |a_in|, |b_in| and the result sign (a[W-1]^b[W-1]), op=MULT, counter=0, go to RUN.
  - DivCtrl=1 with b_in≠0 → latch magnitudes, quotient sign (a^b), remainder sign (a[W-1]), op=DIV, go to RUN.
  - DivCtrl=1 with b_in=0 → go directly to DONE with DivZero=1. HI/LO are not modified.
  - MultCtrl and DivCtrl both high → multiply wins; DivCtrl is ignored.
- RUN: one iteration per cycle for exactly WIDTH cycles; counter increments each cycle and RUN exits when counter reaches WIDTH-1.
  - MULT: unsigned shift-add on magnitudes into a 2*WIDTH accumulator.
  - DIV: unsigned restoring divide (shift remainder left, trial-subtract divisor, set quotient bit when the difference is non-negative).
- FIX: single cycle.
  - MULT: negate the 2*WIDTH product if the sign bit is set; write {hi,lo}.
  - DIV: negate the quotient if the quotient sign is set, negate the remainder if the remainder sign is set; lo=quotient, hi=remainder.
  - Semantics are truncation toward zero; the remainder takes the dividend's sign.
- DONE: done=1 for exactly one cycle, busy=0, then return to IDLE.
  - DivZero stays at its DONE value until the next accepted start, which clears it.
- Latency, with the start cycle counted as cycle 0:
  - Normal op: busy=1 in cycles 1..WIDTH+1; done=1 in cycle WIDTH+2 (cycle 34 for WIDTH=32).
  - Divide-by-zero: busy stays 0; done=1 in cycle 1.
- Starts while state≠IDLE are ignored, including a start in the DONE cycle; no queueing. a_in/b_in are don't-care after capture.
- HI/LO change only in FIX. They are stable from done until the next FIX.
- Overflow case 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0, DivZero=0.
- Multiply produces a full 2*WIDTH result, so it never overflows.

Test Plan:
- MultCtrl, a=7, b=6 → done in cycle 34; hi=0x00000000, lo=0x0000002A; busy high in cycles 1..33.
- MultCtrl, a=0xFFFFFFFD (-3), b=5 → hi=0xFFFFFFFF, lo=0xFFFFFFF1. Then a=b=0x80000000 → hi=0x40000000, lo=0x00000000.
- DivCtrl, a=0xFFFFFFF9 (-7), b=2 → lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). Then a=100, b=7 → lo=14, hi=2, DivZero=0.
- Preload hi=2, lo=14; DivCtrl, b=0 → done and DivZero in cycle 1, busy never high, hi/lo unchanged. The next MultCtrl clears DivZero.
- MultCtrl and DivCtrl together with a=3, b=4 → multiply result lo=12. A MultCtrl pulse at cycle 10 of a running divide is ignored; the divide result is intact.
- Reset driven low at cycle 15 of a multiply → busy, done, hi and lo are 0 immediately, with no clock edge needed. After Reset releases, no done appears and a fresh multiply completes normally.
